// File: rtl/mul_4b_seq_pkg.sv
// Shared definitions for the 4x4 sequential multiplier: state encodings and
// the number of shift-add iterations. Imported by the RTL and the bench.
package mul_4b_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int unsigned N_ITER   = 4;
    localparam logic [1:0]  CNT_LAST = 2'(N_ITER - 1);

endpackage

// File: rtl/mul_4b_seq_rca_4b.sv
// rca_4b: 4-bit ripple-carry adder built from explicit full-adder logic.
module rca_4b (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_c;
    logic [3:0] w_p;

    assign w_c[0] = i_cin;
    assign w_p    = i_a ^ i_b;

    // One full adder per bit; carry ripples from bit 0 upwards.
    always_comb begin
        o_sum = 4'h0;
        for (int i = 0; i < 4; i++) begin
            o_sum[i] = w_p[i] ^ w_c[i];
        end
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_carry
            assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & w_p[g]);
        end
    endgenerate

    assign o_cout = w_c[4];

endmodule

// File: rtl/mul_4b_seq.sv
// mul_4b_seq: unsigned 4x4 -> 8 shift-add multiplier, one add step per clock.
//
//   state | meaning
//   IDLE  | waiting for start; product holds the last result
//   CALC  | four shift-add steps, multiplier consumed LSB first
//   DONE  | product valid, done pulses for one cycle
//
// The accumulator upper nibble is the running partial sum; each step shifts
// {cout, sum, lower nibble} right so the adder carry lands in bit 7.
module mul_4b_seq
    import mul_4b_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product,
    output logic       busy,
    output logic       done
);

    logic [1:0] r_state;
    logic [3:0] r_mcand;
    logic [3:0] r_mplier;
    logic [7:0] r_acc;
    logic [1:0] r_cnt;
    logic [7:0] r_product;

    logic [3:0] w_addend;
    logic [3:0] w_sum;
    logic       w_cout;
    logic [7:0] w_acc_next;

    assign w_addend   = r_mplier[0] ? r_mcand : 4'h0;
    assign w_acc_next = {w_cout, w_sum, r_acc[3:1]};

    rca_4b u_rca (
        .i_a    (r_acc[7:4]),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Sequencer: operand capture, shift-add iterations and product load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mcand   <= 4'h0;
            r_mplier  <= 4'h0;
            r_acc     <= 8'h00;
            r_cnt     <= 2'd0;
            r_product <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= 8'h00;
                        r_cnt    <= 2'd0;
                        r_state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= {1'b0, r_mplier[3:1]};
                    r_cnt    <= r_cnt + 2'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_product <= w_acc_next;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign product = r_product;
    assign busy    = (r_state == ST_CALC) || (r_state == ST_DONE);
    assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_mul_4b_seq.sv
// Self-checking bench for mul_4b_seq: directed scenarios plus an exhaustive,
// randomly perturbed sweep checked against plain a*b arithmetic.
module tb_mul_4b_seq;
    import mul_4b_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] product;
    logic       busy;
    logic       done;

    int         n_checks;
    int         n_errs;
    logic [7:0] last_prod;

    mul_4b_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: start accepted on the first edge, then the
    // operand inputs are replaced by na/nb (must not disturb the result).
    // Returns sampled just after the edge that re-enters IDLE.
    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                          input logic [3:0] na, input logic [3:0] nb,
                          input bit hold);
        logic [7:0] exp_p;
        exp_p = 8'(int'(ia) * int'(ib));
        a     = ia;
        b     = ib;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        a = na;
        b = nb;
        for (int i = 0; i < int'(N_ITER); i++) begin
            chk("busy_calc", 32'(busy), 32'd1);
            chk("done_calc", 32'(done), 32'd0);
            chk("prod_hold", 32'(product), 32'(last_prod));
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd1);
        chk("product", 32'(product), 32'(exp_p));
        last_prod = exp_p;
        tick();
        chk("busy_idle", 32'(busy), 32'd0);
        chk("done_low", 32'(done), 32'd0);
        chk("prod_keep", 32'(product), 32'(last_prod));
    endtask

    initial begin
        n_checks  = 0;
        n_errs    = 0;
        last_prod = 8'h00;
        rst       = 1'b1;
        start     = 1'b0;
        a         = 4'h0;
        b         = 4'h0;

        // Reset held for two cycles.
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prod", 32'(product), 32'd0);

        // 0*0 accepted on the first edge after reset release.
        rst = 1'b0;
        run_op(4'h0, 4'h0, 4'h5, 4'hA, 1'b0);

        // 15*15 exercises the carry into bit 7.
        run_op(4'hF, 4'hF, 4'h0, 4'h0, 1'b0);

        // start held through the operation with changed operands; the
        // held start is only taken after the return to IDLE (3*3).
        run_op(4'h9, 4'h6, 4'h3, 4'h3, 1'b1);
        run_op(4'h3, 4'h3, 4'h0, 4'h0, 1'b0);

        // Reset on the second CALC edge aborts with no done pulse.
        a     = 4'h4;
        b     = 4'h9;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_prod", 32'(product), 32'd0);
        last_prod = 8'h00;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end

        // Back-to-back at the minimum spacing; product holds between.
        run_op(4'h1, 4'hF, 4'h7, 4'h7, 1'b0);
        run_op(4'hF, 4'h1, 4'h2, 4'h2, 1'b0);

        // Exhaustive sweep with random post-accept operands, random
        // held start and random idle gaps.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j), 4'($urandom), 4'($urandom),
                       bit'($urandom_range(0, 1)));
                start = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                        a = 4'($urandom);
                        b = 4'($urandom);
                        tick();
                        chk("gap_idle", 32'(busy), 32'd0);
                        chk("gap_prod", 32'(product), 32'(last_prod));
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
